// File: rtl/dc_fu_axi_read_responder_if.sv
// dc_fu_axi_read_responder_if: AXI4 read address/data channel bundle.
// master: drives AR request and rready; slave: returns R beats.
interface dc_fu_axi_read_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0] axi_araddr;
  logic [LEN_WIDTH-1:0]  axi_arlen;
  logic                  axi_arvalid;
  logic                  axi_arready;
  logic [DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]            axi_rresp;
  logic                  axi_rlast;
  logic                  axi_rvalid;
  logic                  axi_rready;

  modport master (
    output axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport slave (
    input  axi_araddr, axi_arlen, axi_arvalid, axi_rready,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/dc_fu_axi_read_responder.sv
// dc_fu_axi_read_responder: AXI4 AR/R subordinate serving INCR bursts
// from a 1-cycle-latency single-port memory via a 2-entry output buffer.
// Ports: clk, nrst (async active-low), en (global enable),
//   axi (slave modport: AR request in, R beats out),
//   mem_rd_en/mem_addr out, mem_rdata in (valid 1 cycle after rd_en),
//   busy (burst accepted, not yet fully returned).
// Optional: DC_FU_AXI_RESP_ERR_EN flags out-of-range bursts with SLVERR.
module dc_fu_axi_read_responder #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  dc_fu_axi_read_responder_if.slave axi,
  output logic                      mem_rd_en,
  output logic [MEM_DEPTH_LOG2-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      busy
);
  localparam int BS = $clog2(DATA_WIDTH / 8);
  localparam int CW = LEN_WIDTH + 1;

  typedef enum logic [1:0] {
    RESET_WAIT,
    IDLE,
    BURST
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [MEM_DEPTH_LOG2-1:0] r_word;
  logic [LEN_WIDTH-1:0]      r_len;
  logic [CW-1:0]             r_issued;
  logic [CW-1:0]             r_ret;
  logic                      r_err;
  logic                      r_infl;
  logic                      r_infl_last;

  logic [DATA_WIDTH-1:0] r_fdata [2];
  logic [1:0]            r_fresp [2];
  logic                  r_flast [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;

  logic                  w_ar_hs;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_last_pop;
  logic                  w_err;
  logic                  w_byp;
  logic [1:0]            w_occ;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic [1:0]            w_in_resp;
  logic [ADDR_WIDTH-1:0] w_word_full;
  logic                  w_unused;

  assign w_word_full = axi.axi_araddr >> BS;
  assign w_unused = ^{axi.axi_araddr, w_word_full};

`ifdef DC_FU_AXI_RESP_ERR_EN
  localparam int EW = MEM_DEPTH_LOG2 + LEN_WIDTH + 1;
  localparam logic [EW-1:0] LP_DEPTH = EW'(1) << MEM_DEPTH_LOG2;
  logic [EW-1:0] w_end;
  assign w_end = EW'(w_word_full[MEM_DEPTH_LOG2-1:0])
               + EW'(axi.axi_arlen) + EW'(1);
  assign w_err = ((axi.axi_araddr >> (BS + MEM_DEPTH_LOG2)) != '0)
              || (w_end > LP_DEPTH);
`else
  assign w_err = 1'b0;
`endif

  // occupancy counts the beat arriving from memory this cycle
  assign w_occ = r_cnt + {1'b0, r_infl};

  assign axi.axi_arready = (r_state == IDLE) && en;
  assign w_ar_hs = axi.axi_arvalid && axi.axi_arready;

  assign axi.axi_rvalid = (w_occ != 2'd0) && en;
  assign w_pop = axi.axi_rvalid && axi.axi_rready;
  assign w_last_pop = w_pop && (r_ret == {1'b0, r_len});

  // no issue credit from a same-cycle pop: resumes the cycle after
  assign w_issue = en && (r_state == BURST)
                && (r_issued <= {1'b0, r_len})
                && (w_occ < 2'd2);

  assign mem_rd_en = w_issue && !r_err;
  assign mem_addr = r_word;
  assign busy = (r_state == BURST);

  // flagged bursts still run the issue timing, with data forced to 0
  assign w_in_data = r_err ? '0 : mem_rdata;
  assign w_in_resp = r_err ? 2'b10 : 2'b00;

  // empty buffer: the arriving beat is presented directly
  assign w_byp = (r_cnt == 2'd0) && r_infl;
  assign axi.axi_rdata = w_byp ? w_in_data : r_fdata[r_rp];
  assign axi.axi_rresp = w_byp ? w_in_resp : r_fresp[r_rp];
  assign axi.axi_rlast = w_byp ? r_infl_last : r_flast[r_rp];

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      RESET_WAIT: if (en) w_state_nx = IDLE;
      IDLE:       if (w_ar_hs) w_state_nx = BURST;
      BURST:      if (w_last_pop) w_state_nx = IDLE;
      default:    w_state_nx = RESET_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= RESET_WAIT;
    end else if (en) begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_word   <= '0;
      r_len    <= '0;
      r_issued <= '0;
      r_ret    <= '0;
      r_err    <= 1'b0;
    end else if (w_ar_hs) begin
      r_word   <= w_word_full[MEM_DEPTH_LOG2-1:0];
      r_len    <= axi.axi_arlen;
      r_issued <= '0;
      r_ret    <= '0;
      r_err    <= w_err;
    end else begin
      if (w_issue) begin
        r_word   <= r_word + 1'b1;
        r_issued <= r_issued + 1'b1;
      end
      if (w_pop) begin
        r_ret <= r_ret + 1'b1;
      end
    end
  end

  // memory data is captured even while en is low
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_fdata[0]  <= '0;
      r_fdata[1]  <= '0;
      r_fresp[0]  <= 2'b00;
      r_fresp[1]  <= 2'b00;
      r_flast[0]  <= 1'b0;
      r_flast[1]  <= 1'b0;
      r_wp        <= 1'b0;
      r_rp        <= 1'b0;
      r_cnt       <= 2'd0;
      r_infl      <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      if (r_infl) begin
        r_fdata[r_wp] <= w_in_data;
        r_fresp[r_wp] <= w_in_resp;
        r_flast[r_wp] <= r_infl_last;
        r_wp          <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      r_cnt       <= w_occ - {1'b0, w_pop};
      r_infl      <= w_issue;
      r_infl_last <= (r_issued == {1'b0, r_len});
    end
  end
endmodule

// File: tb/tb_dc_fu_axi_read_responder.sv
// tb_dc_fu_axi_read_responder: directed bench with a burst-level
// scoreboard checking every R beat, memory read and status cycle.
module tb_dc_fu_axi_read_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int ML = 12;
  localparam int LW = 8;

  logic          clk;
  logic          nrst;
  logic          en;
  logic          mem_rd_en;
  logic [ML-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad = 0;

  dc_fu_axi_read_responder_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) axi_if ();

  dc_fu_axi_read_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_DEPTH_LOG2(ML), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .en(en),
    .axi(axi_if.slave),
    .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input int w);
    return 32'hA000_0000 + 32'(w * 7);
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= memfn(int'(mem_addr));
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
    logic        rd;
  } beat_t;

  beat_t exp_q[$];
  int    addr_q[$];
  int    outst = 0;
  bit    en_seen = 0;

  always @(negedge clk) begin
    if (!nrst) begin
      exp_q.delete();
      addr_q.delete();
      outst = 0;
      en_seen = 0;
      chk("rst_arready", axi_if.axi_arready, 0);
      chk("rst_rvalid", axi_if.axi_rvalid, 0);
      chk("rst_rlast", axi_if.axi_rlast, 0);
      chk("rst_rresp", axi_if.axi_rresp, 0);
      chk("rst_rdata", axi_if.axi_rdata, 0);
      chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_busy", busy, 0);
    end else begin
      chk("busy", busy, exp_q.size() != 0);
      chk("arready", axi_if.axi_arready,
          en && en_seen && exp_q.size() == 0);
      if (!en) chk("rvalid_en_low", axi_if.axi_rvalid, 0);
      if (mem_rd_en) begin
        chk("rd_expected", addr_q.size() != 0, 1);
        if (addr_q.size() != 0) begin
          chk("rd_addr", mem_addr, addr_q[0]);
          void'(addr_q.pop_front());
        end
        outst++;
        chk("inflight_le2", outst <= 2, 1);
      end
      if (axi_if.axi_rvalid) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          chk("rdata", axi_if.axi_rdata, exp_q[0].d);
          chk("rresp", axi_if.axi_rresp, exp_q[0].r);
          chk("rlast", axi_if.axi_rlast, exp_q[0].l);
          if (axi_if.axi_rready) begin
            if (exp_q[0].rd) outst--;
            void'(exp_q.pop_front());
          end
        end
      end
      if (axi_if.axi_arvalid && axi_if.axi_arready) begin
        longint w0;
        bit err;
        w0 = longint'(axi_if.axi_araddr >> 2);
`ifdef DC_FU_AXI_RESP_ERR_EN
        err = ((axi_if.axi_araddr >> 14) != 0)
           || (w0 + longint'(axi_if.axi_arlen) + 1 > 4096);
`else
        err = 0;
`endif
        for (int i = 0; i <= int'(axi_if.axi_arlen); i++) begin
          beat_t b;
          int w;
          w = int'((w0 + i) % 4096);
          b.d = err ? 32'h0 : memfn(w);
          b.r = err ? 2'b10 : 2'b00;
          b.l = (i == int'(axi_if.axi_arlen));
          b.rd = !err;
          exp_q.push_back(b);
          if (!err) addr_q.push_back(w);
        end
      end
      if (en) en_seen = 1;
    end
  end

  logic [31:0] b_data [16];
  logic [1:0]  b_resp [16];
  logic        b_last [16];
  int          b_rds [16];
  int          rd_addr [16];

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l);
    @(posedge clk); #1;
    axi_if.axi_araddr = a;
    axi_if.axi_arlen = l;
    axi_if.axi_arvalid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (axi_if.axi_arready) break;
    end
    chk("ar_accept", axi_if.axi_arready, 1);
    @(posedge clk); #1;
    axi_if.axi_arvalid = 1'b0;
  endtask

  task automatic collect(input int n, input int budget,
                         input logic [15:0] pat,
                         output int got, output int rds);
    got = 0;
    rds = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clk);
      if (mem_rd_en) begin
        if (rds < 16) rd_addr[rds] = int'(mem_addr);
        rds++;
      end
      if (axi_if.axi_rvalid && axi_if.axi_rready) begin
        b_data[got] = axi_if.axi_rdata;
        b_resp[got] = axi_if.axi_rresp;
        b_last[got] = axi_if.axi_rlast;
        b_rds[got] = rds;
        got++;
      end
      if (got < n) begin
        @(posedge clk); #1;
        axi_if.axi_rready = pat[k % 16];
      end
    end
    chk("beat_count", got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  initial begin
    int got;
    int rds;
    nrst = 1'b0;
    en = 1'b1;
    axi_if.axi_araddr = '0;
    axi_if.axi_arlen = '0;
    axi_if.axi_arvalid = 1'b0;
    axi_if.axi_rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_arready", axi_if.axi_arready, 0);
    chk("init_busy", busy, 0);
    @(posedge clk); #1;
    nrst = 1'b1;

    // single beat, latency pinned
    send_ar(32'h10, 8'd0);
    @(negedge clk);
    chk("t1_rd_en", mem_rd_en, 1);
    chk("t1_mem_addr", mem_addr, 4);
    chk("t1_no_early_rvalid", axi_if.axi_rvalid, 0);
    @(negedge clk);
    chk("t1_rvalid", axi_if.axi_rvalid, 1);
    chk("t1_rlast", axi_if.axi_rlast, 1);
    chk("t1_rresp", axi_if.axi_rresp, 0);
    chk("t1_rdata", axi_if.axi_rdata, 32'hA000_001C);
    @(negedge clk);
    chk("t1_arready_after", axi_if.axi_arready, 1);
    chk("t1_busy_after", busy, 0);

    // four beats with a backpressure window
    send_ar(32'h0, 8'd3);
    axi_if.axi_rready = 1'b0;
    collect(4, 40, 16'hFFF0, got, rds);
    chk("t2_reads_before_pop", b_rds[0], 2);
    chk("t2_d0", b_data[0], 32'hA000_0000);
    chk("t2_d1", b_data[1], 32'hA000_0007);
    chk("t2_d2", b_data[2], 32'hA000_000E);
    chk("t2_d3", b_data[3], 32'hA000_0015);
    chk("t2_lasts", {b_last[3], b_last[2], b_last[1], b_last[0]}, 4'b1000);

    // top of memory
    send_ar(32'h3FFC, 8'd1);
    collect(2, 20, 16'hFFFF, got, rds);
    chk("t3_last", {b_last[1], b_last[0]}, 2'b10);
`ifdef DC_FU_AXI_RESP_ERR_EN
    chk("t3_no_reads", rds, 0);
    chk("t3_resp0", b_resp[0], 2'b10);
    chk("t3_resp1", b_resp[1], 2'b10);
    chk("t3_d0", b_data[0], 0);
    chk("t3_d1", b_data[1], 0);
`else
    chk("t3_reads", rds, 2);
    chk("t3_a0", rd_addr[0], 4095);
    chk("t3_a1", rd_addr[1], 0);
    chk("t3_resp0", b_resp[0], 2'b00);
    chk("t3_resp1", b_resp[1], 2'b00);
    chk("t3_d0", b_data[0], 32'hA000_6FF9);
    chk("t3_d1", b_data[1], 32'hA000_0000);
`endif

    // reset in the middle of a burst
    send_ar(32'h100, 8'd3);
    collect(2, 20, 16'hFFFF, got, rds);
    chk("t4_d0", b_data[0], 32'hA000_01C0);
    chk("t4_d1", b_data[1], 32'hA000_01C7);
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk("t4_rst_rvalid", axi_if.axi_rvalid, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    send_ar(32'h20, 8'd0);
    collect(1, 20, 16'hFFFF, got, rds);
    chk("t4_new_d", b_data[0], 32'hA000_0038);
    chk("t4_new_last", b_last[0], 1);
    chk("t4_new_resp", b_resp[0], 0);

    // enable stall mid-burst
    send_ar(32'h40, 8'd3);
    collect(1, 20, 16'hFFFF, got, rds);
    chk("t5_d0", b_data[0], 32'hA000_0070);
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t5_stall_rvalid", axi_if.axi_rvalid, 0);
      chk("t5_stall_arready", axi_if.axi_arready, 0);
    end
    @(posedge clk); #1;
    en = 1'b1;
    collect(3, 20, 16'hFFFF, got, rds);
    chk("t5_d1", b_data[0], 32'hA000_0077);
    chk("t5_d2", b_data[1], 32'hA000_007E);
    chk("t5_d3", b_data[2], 32'hA000_0085);
    chk("t5_lasts", {b_last[2], b_last[1], b_last[0]}, 3'b100);

    // eight beats under irregular rready
    send_ar(32'h200, 8'd7);
    collect(8, 80, 16'hA6C9, got, rds);
    chk("t6_d0", b_data[0], 32'hA000_0380);
    chk("t6_d7", b_data[7], 32'hA000_03B1);
    chk("t6_last7", b_last[7], 1);
    chk("t6_last6", b_last[6], 0);
    @(posedge clk); #1;
    axi_if.axi_rready = 1'b1;

    repeat (3) @(negedge clk);
    chk("drain_beats", exp_q.size(), 0);
    chk("drain_reads", addr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dc_fu_axi_read_responder.md
# dc_fu_axi_read_responder

AXI4 read-channel responder (AR/R subordinate) serving the fetch unit DMA's read bursts from a synchronous single-port memory. Sits between the fetch unit DMA's AXI read master and an on-chip frame-buffer SRAM, or acts as the memory model in the HDMI scaler bench. It accepts one INCR burst at a time, issues one memory read per beat and returns beats with correct `rlast` and `rresp`. A 2-entry output buffer gives full throughput under `rready` backpressure.

## Interface
- `ADDR_WIDTH`, 32, AXI byte address width.
- `DATA_WIDTH`, 32, AXI and memory data width; power of two, at least 8.
- `MEM_DEPTH_LOG2`, 12, log2 of memory depth in words.
- `LEN_WIDTH`, 8, width of `axi_arlen`; burst length is `arlen+1` beats.

Ports:
- `clk` in 1: clock.
- `nrst` in 1: reset, asynchronous, active-low.
- `en` in 1: global enable. Low freezes all registers and masks handshakes.
- `axi_araddr` in `ADDR_WIDTH`: burst start byte address.
- `axi_arlen` in `LEN_WIDTH`: beats minus one.
- `axi_arvalid` in 1, `axi_arready` out 1: AR handshake.
- `axi_rdata` out `DATA_WIDTH`: read data.
- `axi_rresp` out 2: `00` OKAY, `10` SLVERR.
- `axi_rlast` out 1: final beat of burst.
- `axi_rvalid` out 1, `axi_rready` in 1: R handshake.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out `MEM_DEPTH_LOG2`: memory word address.
- `mem_rdata` in `DATA_WIDTH`: valid exactly 1 cycle after `mem_rd_en`.
- `busy` out 1: burst accepted and not yet fully returned.

## Operation
- FSM states:
  - RESET_WAIT (reset state) -> IDLE on first `en` cycle after reset release.
  - IDLE: `arready_r`=1. On `arvalid && axi_arready` -> BURST. On entering BURST, latch:
    - word address = `araddr >> log2(DATA_WIDTH/8)`; low byte bits are ignored.
    - `len_r` = `arlen`.
    - issue counter and return counter cleared to 0.
    - error flag.
  - BURST: `arready_r`=0.
    - Issue one memory read per cycle while issued ≤ `len_r` and (buffer occupancy + reads in flight) < 2.
    - `mem_addr` increments by 1 per issue and wraps modulo 2^`MEM_DEPTH_LOG2`.
  - BURST -> IDLE in the cycle the beat with return index == `len_r` is popped (`rvalid && rready`). `arready` is 1 in the following cycle.
- Output buffer: 2-entry FIFO of {data, resp, last}.
  - Push on the cycle after `mem_rd_en`.
  - `axi_rvalid` = FIFO non-empty && `en`; head drives `rdata`, `rresp` and `rlast`.
  - Pop on `rvalid && rready`. Push and pop in the same cycle are legal, and occupancy is unchanged.
  - `rlast` is set on the entry whose beat index == `len_r`.
- `axi_arready` = `arready_r && en`. No AR is accepted while BURST (one outstanding burst).
- `busy` = state is BURST.
- `arlen`=0 yields a single beat with `rlast`=1.
- Reset mid-burst: FIFO, counters and FSM are cleared. No further beats of that burst are produced.
- Reset values: `axi_arready` 0, `axi_rvalid` 0, `axi_rlast` 0, `axi_rresp` 00, `axi_rdata` 0, `mem_rd_en` 0, `mem_addr` 0, `busy` 0.

## Timing
- AR handshake at cycle T.
- `mem_rd_en` with the start address at T+1.
- First `rvalid` at T+2.
- With `rready` held high: one beat per cycle, so N beats finish at T+1+N.
- `rready` low: `rvalid`, `rdata`, `rresp` and `rlast` stay stable until the pop.
  - Issuing stops once occupancy + in-flight = 2.
  - Issuing resumes the cycle after a pop.
- Back-to-back bursts: the next AR handshake is possible no earlier than 1 cycle after the last pop.
- `en` low: state and outputs are held (`rvalid` and `arready` are forced to 0), and the memory returning data that cycle is captured normally.

## Configuration
- `DC_FU_AXI_RESP_ERR_EN` defined:
  - A burst whose byte range exceeds 2^`MEM_DEPTH_LOG2` words, or whose upper `araddr` bits above the memory range are non-zero, is flagged at AR.
  - A flagged burst returns `arlen+1` beats, each with `rresp`=`10` and `rdata`=0.
  - No `mem_rd_en` is asserted for a flagged burst; beat timing is otherwise identical.
- Not defined: upper address bits are ignored, the address wraps, and `rresp` is always `00`.

## Test plan
- Reset, then `araddr`=0x10, `arlen`=0, `rready`=1 -> `mem_addr`=4 at T+1; one beat at T+2 with `rlast`=1, `rresp`=00; `arready`=1 at T+3.
- `araddr`=0x0, `arlen`=3, `rready` low T+2..T+5 -> at most 2 `mem_rd_en` before the first pop; beats 0..3 in order with `rdata` stable while stalled; `rlast` only on beat 3.
- `araddr`=(4095*4), `arlen`=1, macro off -> `mem_addr` 4095 then 0; two beats with `rresp`=00.
- Same request with `DC_FU_AXI_RESP_ERR_EN` -> no `mem_rd_en`; two beats with `rresp`=10, `rdata`=0, `rlast` on the second.
- `arlen`=3, `nrst` pulsed after beat 1 -> all outputs at reset values; a new burst (`arlen`=0) then completes normally.
- `en` low for 3 cycles mid-burst with `rready`=1 -> no pops, `rvalid`=0 and `arready`=0 during the stall; the remaining beats resume with correct order and `rlast`.
